sprite_render_engine: RTL and testbench
=======================================

SPRITE_RENDER_ENGINE -- requirements
Module: sprite_render_engine

Interface
REQ-001 Parameter NUM_CHARS, default 5, number of characters drawn per frame (index 0 = Pacman, 1..NUM_CHARS-1 = ghosts).
REQ-002 Parameter SPRITE_W, default 5, sprite width in pixels.
REQ-003 Parameter SPRITE_H, default 5, sprite height in pixels.
REQ-004 Parameter TILE_PITCH, default 7, screen pixels per board cell.
REQ-005 Parameter ORIGIN_OFFSET, default 1, pixel offset added to both coordinates.
REQ-006 Parameter TRANSPARENT, default 1; 1 = plot only set pixels, 0 = plot every pixel, with clear pixels drawn as colour 0.
REQ-007 Port clock_50, input, 1, the single clock; every register is clocked on its rising edge.
REQ-008 Port reset, input, 1, synchronous, active-high reset.
REQ-009 Port start, input, 1, single-cycle request to render one frame.
REQ-010 Port pacman_dir, input, 2, Pacman orientation: 0 left, 1 right, 2 up, 3 down.
REQ-011 Port char_visible, input, NUM_CHARS, per-character draw enable.
REQ-012 Port char_sel, output, clog2(NUM_CHARS), character index presented to the character registers.
REQ-013 Port char_x / char_y, input, 8 each, board cell of the selected character, valid combinationally from char_sel.
REQ-014 Port vga_x / vga_y, output, 8 each, pixel coordinate.
REQ-015 Port vga_color, output, 3, pixel colour.
REQ-016 Port vga_plot, output, 1, pixel write strobe.
REQ-017 Port busy, output, 1, high from the cycle after start is accepted until the cycle done is high, inclusive.
REQ-018 Port done, output, 1, one-cycle pulse at end of frame.

Function
REQ-019 The FSM SHALL have states IDLE, LOAD, DRAW, NEXT, FIN.
- IDLE: waits for start.
- LOAD: latches char_x/char_y into base registers. Goes to DRAW if char_visible[char_sel], else to NEXT.
- DRAW: visits pixels row-major, one per cycle. Goes to NEXT after (SPRITE_W-1, SPRITE_H-1).
- NEXT: goes to FIN if char_sel = NUM_CHARS-1, else increments char_sel and goes to LOAD.
- FIN: asserts done and goes to IDLE.
REQ-020 start SHALL be accepted only in IDLE and SHALL be ignored in all other states. Acceptance SHALL reset char_sel to 0 and enter LOAD.
REQ-021 A visible character SHALL cost 1 + SPRITE_W*SPRITE_H + 1 cycles; an invisible character SHALL cost 2 cycles.
REQ-022 The registered output for a pixel at (col c, row r) SHALL be vga_x = (base_x*TILE_PITCH + c + ORIGIN_OFFSET) mod 256, and likewise for vga_y with base_y and r. Overflow SHALL wrap silently.
REQ-023 The pixel at column c SHALL be bit c (LSB = leftmost) of row r of the bitmap.
REQ-024 Bitmaps:
- Pacman left: rows 01111, 11111, 00111, 00011, 00111.
- Pacman right: rows 00111, 01111, 11111, 11110, 11111.
- Pacman up: transpose of left.
- Pacman down: transpose of right.
- Ghost: rows 00100, 01010, 01110, 01110, 00000.
REQ-025 Colours:
- Pacman: 3'b110.
- Ghost i: GHOST_PALETTE[(i-1) mod 4], where GHOST_PALETTE = {001, 100, 010, 110}.
REQ-026 vga_plot SHALL be 1 only for DRAW pixels that are set, or for every DRAW pixel when TRANSPARENT=0. It SHALL be 0 in all other states.
REQ-027 vga_x, vga_y, vga_color and vga_plot SHALL be registered and appear exactly one cycle after the pixel is visited.
REQ-028 pacman_dir SHALL be sampled in LOAD of character 0 and held for that sprite. A change mid-sprite SHALL not affect it.
REQ-029 The frame in progress SHALL finish and set done before any new start is accepted.

Reset
REQ-030 While reset is high, the state SHALL be IDLE and char_sel, vga_x, vga_y, vga_color, vga_plot, busy and done SHALL all be 0.
REQ-031 Reset asserted mid-frame SHALL abort it: no further plot, no done pulse.
REQ-032 The first start SHALL be accepted on the first cycle after reset deasserts.

Structure
REQ-033 The bitmaps, GHOST_PALETTE, colour constants and direction encodings SHALL live in the shared package pacman_gfx_pkg.
REQ-034 Bitmap and colour lookup SHALL be in a combinational sub-module sprite_rom (inputs: char index, direction, row, col; outputs: pixel bit, colour). The FSM and address arithmetic SHALL stay in the top module.

Verification
REQ-035 Defaults, all visible, char (x,y) = (0,0): start -> done 137 cycles later; 17 + 4*9 = 53 plots; Pacman's first plot at (1,1) with colour 110.
REQ-036 TRANSPARENT=0, all visible -> exactly 125 plots, and the clear ghost row 4 is plotted with colour 000.
REQ-037 char_visible = 5'b00101 -> plots only for chars 0 and 2; done 2 + 27*2 + 2*3 = 62 cycles after start.
REQ-038 pacman_dir = 1, Pacman at (36,36) -> 21 plots; x,y wrap to 253..257 mod 256, i.e. 253, 254, 255, 0, 1.
REQ-039 Reset pulsed at cycle 40 of a frame -> all outputs 0 the next cycle, no done; a new start then produces a full frame.
REQ-040 start pulsed while busy -> ignored; exactly one done pulse per accepted start.

Source files
------------

// File: rtl/pacman_gfx_pkg.sv
// Shared graphics constants for the Pacman sprite renderer: bitmaps,
// palette, direction encodings and the frame FSM state type.
package pacman_gfx_pkg;

    localparam logic [7:0] BM_ROWS = 8'd5;
    localparam logic [7:0] BM_COLS = 8'd5;

    // Row r is bm[r]; bit c of a row is column c, LSB = leftmost pixel.
    typedef logic [4:0][4:0] bitmap_t;

    typedef enum logic [1:0] {
        DIR_LEFT  = 2'd0,
        DIR_RIGHT = 2'd1,
        DIR_UP    = 2'd2,
        DIR_DOWN  = 2'd3
    } dir_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_LOAD = 3'd1,
        ST_DRAW = 3'd2,
        ST_NEXT = 3'd3,
        ST_FIN  = 3'd4
    } state_e;

    localparam logic [2:0] COLOR_PACMAN = 3'b110;
    localparam logic [2:0] COLOR_CLEAR  = 3'b000;

    // Element [0] is the first ghost's colour.
    localparam logic [3:0][2:0] GHOST_PALETTE = {3'b110, 3'b010, 3'b100, 3'b001};

    // Rows listed bottom (row 4) to top (row 0) so that bm[0] is the top row.
    localparam bitmap_t BM_PAC_LEFT  = {5'b00111, 5'b00011, 5'b00111, 5'b11111, 5'b01111};
    localparam bitmap_t BM_PAC_RIGHT = {5'b11111, 5'b11110, 5'b11111, 5'b01111, 5'b00111};
    localparam bitmap_t BM_GHOST     = {5'b00000, 5'b01110, 5'b01110, 5'b01010, 5'b00100};

    // Pixel lookup; anything outside the 5x5 artwork reads as clear, so
    // larger sprite windows simply get an empty border.
    function automatic logic bm_pixel(input bitmap_t bm, input logic [7:0] row,
                                      input logic [7:0] col);
        logic px;
        px = 1'b0;
        if ((row < BM_ROWS) && (col < BM_COLS)) begin
            px = bm[row[2:0]][col[2:0]];
        end
        return px;
    endfunction

endpackage

// File: rtl/sprite_rom.sv
// Combinational sprite bitmap and colour lookup. Up/down Pacman are the
// transposes of left/right, obtained by swapping row and column on lookup.
module sprite_rom
    import pacman_gfx_pkg::*;
#(
    parameter int CSW = 3
) (
    input  logic [CSW-1:0] i_char_idx,
    input  logic [1:0]     i_dir,
    input  logic [7:0]     i_row,
    input  logic [7:0]     i_col,
    output logic           o_pixel,
    output logic [2:0]     o_color
);

    logic [1:0] w_ghost_ofs;

    assign w_ghost_ofs = 2'(i_char_idx) - 2'd1;

    // Select bitmap by character and orientation, and the matching colour.
    always_comb begin
        o_pixel = 1'b0;
        o_color = COLOR_PACMAN;
        if (i_char_idx == '0) begin
            case (i_dir)
                DIR_LEFT:  o_pixel = bm_pixel(BM_PAC_LEFT,  i_row, i_col);
                DIR_RIGHT: o_pixel = bm_pixel(BM_PAC_RIGHT, i_row, i_col);
                DIR_UP:    o_pixel = bm_pixel(BM_PAC_LEFT,  i_col, i_row);
                DIR_DOWN:  o_pixel = bm_pixel(BM_PAC_RIGHT, i_col, i_row);
                default:   o_pixel = 1'b0;
            endcase
        end else begin
            o_pixel = bm_pixel(BM_GHOST, i_row, i_col);
            o_color = GHOST_PALETTE[w_ghost_ofs];
        end
    end

endmodule

// File: rtl/sprite_render_engine.sv
// Frame renderer: walks every character, streams one sprite pixel per
// cycle to a VGA-style plot interface, then pulses done.
//
//   state | meaning
//   IDLE  | wait for start
//   LOAD  | latch board cell of char_sel (and Pacman direction for char 0)
//   DRAW  | visit sprite pixels row-major, one per cycle
//   NEXT  | advance to next character or finish
//   FIN   | end of frame; done pulses on the following cycle
module sprite_render_engine
    import pacman_gfx_pkg::*;
#(
    parameter int NUM_CHARS     = 5,
    parameter int SPRITE_W      = 5,
    parameter int SPRITE_H      = 5,
    parameter int TILE_PITCH    = 7,
    parameter int ORIGIN_OFFSET = 1,
    parameter int TRANSPARENT   = 1,
    localparam int CSW = (NUM_CHARS > 1) ? $clog2(NUM_CHARS) : 1
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic                 start,
    input  logic [1:0]           pacman_dir,
    input  logic [NUM_CHARS-1:0] char_visible,
    output logic [CSW-1:0]       char_sel,
    input  logic [7:0]           char_x,
    input  logic [7:0]           char_y,
    output logic [7:0]           vga_x,
    output logic [7:0]           vga_y,
    output logic [2:0]           vga_color,
    output logic                 vga_plot,
    output logic                 busy,
    output logic                 done
);

    localparam logic [7:0]     LAST_COL  = 8'(SPRITE_W - 1);
    localparam logic [7:0]     LAST_ROW  = 8'(SPRITE_H - 1);
    localparam logic [7:0]     PITCH8    = 8'(TILE_PITCH);
    localparam logic [7:0]     OFS8      = 8'(ORIGIN_OFFSET);
    localparam logic [CSW-1:0] LAST_CHAR = CSW'(NUM_CHARS - 1);

    state_e         r_state;
    state_e         w_next_state;
    logic [CSW-1:0] r_char_sel;
    logic [7:0]     r_col;
    logic [7:0]     r_row;
    logic [7:0]     r_base_x;
    logic [7:0]     r_base_y;
    logic [1:0]     r_dir;
    logic [7:0]     r_vga_x;
    logic [7:0]     r_vga_y;
    logic [2:0]     r_vga_color;
    logic           r_vga_plot;
    logic           r_done;

    logic           w_last_pix;
    logic           w_char_vis;
    logic           w_plot;
    logic           w_rom_pixel;
    logic [2:0]     w_rom_color;
    logic [7:0]     w_pix_x;
    logic [7:0]     w_pix_y;

    assign w_last_pix = (r_col == LAST_COL) && (r_row == LAST_ROW);
    assign w_char_vis = char_visible[r_char_sel];

    // 8-bit arithmetic throughout so off-screen coordinates wrap mod 256.
    assign w_pix_x = r_base_x * PITCH8 + r_col + OFS8;
    assign w_pix_y = r_base_y * PITCH8 + r_row + OFS8;

    sprite_rom #(
        .CSW(CSW)
    ) u_rom (
        .i_char_idx (r_char_sel),
        .i_dir      (r_dir),
        .i_row      (r_row),
        .i_col      (r_col),
        .o_pixel    (w_rom_pixel),
        .o_color    (w_rom_color)
    );

    // State register.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state decode and plot qualification.
    always_comb begin
        w_next_state = r_state;
        w_plot       = 1'b0;
        case (r_state)
            ST_IDLE: if (start) w_next_state = ST_LOAD;
            ST_LOAD: w_next_state = w_char_vis ? ST_DRAW : ST_NEXT;
            ST_DRAW: begin
                w_plot = (TRANSPARENT == 0) || w_rom_pixel;
                if (w_last_pix) w_next_state = ST_NEXT;
            end
            ST_NEXT: w_next_state = (r_char_sel == LAST_CHAR) ? ST_FIN : ST_LOAD;
            ST_FIN:  w_next_state = ST_IDLE;
            default: w_next_state = ST_IDLE;
        endcase
    end

    // Character index, sprite base, direction and pixel cursor.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_char_sel <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_base_x   <= '0;
            r_base_y   <= '0;
            r_dir      <= '0;
        end else begin
            case (r_state)
                ST_IDLE: if (start) r_char_sel <= '0;
                ST_LOAD: begin
                    r_base_x <= char_x;
                    r_base_y <= char_y;
                    r_col    <= '0;
                    r_row    <= '0;
                    if (r_char_sel == '0) r_dir <= pacman_dir;
                end
                ST_DRAW: begin
                    if (r_col == LAST_COL) begin
                        r_col <= '0;
                        r_row <= r_row + 8'd1;
                    end else begin
                        r_col <= r_col + 8'd1;
                    end
                end
                ST_NEXT: if (r_char_sel != LAST_CHAR) r_char_sel <= r_char_sel + CSW'(1);
                default: ;
            endcase
        end
    end

    // Registered pixel outputs and end-of-frame pulse.
    always_ff @(posedge clock_50) begin
        if (reset) begin
            r_vga_x     <= '0;
            r_vga_y     <= '0;
            r_vga_color <= '0;
            r_vga_plot  <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_vga_plot <= w_plot;
            r_done     <= (r_state == ST_FIN);
            if (r_state == ST_DRAW) begin
                r_vga_x     <= w_pix_x;
                r_vga_y     <= w_pix_y;
                r_vga_color <= w_rom_pixel ? w_rom_color : COLOR_CLEAR;
            end
        end
    end

    assign char_sel  = r_char_sel;
    assign vga_x     = r_vga_x;
    assign vga_y     = r_vga_y;
    assign vga_color = r_vga_color;
    assign vga_plot  = r_vga_plot;
    assign done      = r_done;
    // Covers the whole frame plus the cycle carrying the done pulse.
    assign busy      = (r_state != ST_IDLE) || r_done;

endmodule

// File: tb/tb_sprite_render_engine.sv
// Directed bench for sprite_render_engine: one transparent and one opaque
// instance driven in lockstep, with hand-computed frame expectations.
module tb_sprite_render_engine;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic [1:0] pacman_dir;
    logic [4:0] char_visible;
    logic [7:0] pos_x;
    logic [7:0] pos_y;

    logic [2:0] char_sel_t, char_sel_o;
    logic [7:0] vga_x_t, vga_y_t, vga_x_o, vga_y_o;
    logic [2:0] vga_color_t, vga_color_o;
    logic       vga_plot_t, vga_plot_o, busy_t, busy_o, done_t, done_o;

    int n_total = 0;
    int n_bad   = 0;

    int         plots_t, plots_o, dones_t, dones_o, ghost_r4_clear_o, row0_t, x0_t;
    bit         seen_first;
    logic [7:0] first_x, first_y, last_x, last_y;
    logic [2:0] first_col;
    logic [2:0] char_col [8];
    int         cyc;

    always #5 clk = ~clk;

    sprite_render_engine dut_t (
        .clock_50     (clk),
        .reset        (reset),
        .start        (start),
        .pacman_dir   (pacman_dir),
        .char_visible (char_visible),
        .char_sel     (char_sel_t),
        .char_x       (pos_x),
        .char_y       (pos_y),
        .vga_x        (vga_x_t),
        .vga_y        (vga_y_t),
        .vga_color    (vga_color_t),
        .vga_plot     (vga_plot_t),
        .busy         (busy_t),
        .done         (done_t)
    );

    sprite_render_engine #(.TRANSPARENT(0)) dut_o (
        .clock_50     (clk),
        .reset        (reset),
        .start        (start),
        .pacman_dir   (pacman_dir),
        .char_visible (char_visible),
        .char_sel     (char_sel_o),
        .char_x       (pos_x),
        .char_y       (pos_y),
        .vga_x        (vga_x_o),
        .vga_y        (vga_y_o),
        .vga_color    (vga_color_o),
        .vga_plot     (vga_plot_o),
        .busy         (busy_o),
        .done         (done_o)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic clr_mon();
        plots_t = 0; plots_o = 0; dones_t = 0; dones_o = 0;
        ghost_r4_clear_o = 0; row0_t = 0; x0_t = 0;
        seen_first = 1'b0;
        first_x = '0; first_y = '0; last_x = '0; last_y = '0; first_col = '0;
        for (int i = 0; i < 8; i++) char_col[i] = 3'd7;
    endtask

    // Advance to the next falling edge and record what both DUTs show there.
    task automatic tick();
        @(negedge clk);
        if (vga_plot_t) begin
            plots_t++;
            if (!seen_first) begin
                seen_first = 1'b1;
                first_x    = vga_x_t;
                first_y    = vga_y_t;
                first_col  = vga_color_t;
            end
            last_x = vga_x_t;
            last_y = vga_y_t;
            char_col[char_sel_t] = vga_color_t;
            if (vga_y_t == 8'd1) row0_t++;
            if (vga_x_t == 8'd0) x0_t++;
        end
        if (done_t) dones_t++;
        if (vga_plot_o) begin
            plots_o++;
            if (char_sel_o != 3'd0 && vga_y_o == 8'd5 && vga_color_o == 3'b000)
                ghost_r4_clear_o++;
        end
        if (done_o) dones_o++;
    endtask

    // Issue one start and run until done (bounded). Cycle 1 is the first
    // cycle after the start-sampling edge; returns the cycle done is seen.
    task automatic run_frame(input logic [4:0] vis, input logic [1:0] dir,
                             input logic [7:0] px, input logic [7:0] py,
                             input int poke_at, input int dir_at,
                             input logic [1:0] dir2, input bit rel_rst,
                             output int cycles);
        char_visible = vis;
        pacman_dir   = dir;
        pos_x        = px;
        pos_y        = py;
        clr_mon();
        chk("busy_before_start", 32'(busy_t), 0);
        start = 1'b1;
        if (rel_rst) reset = 1'b0;
        cycles = 0;
        do begin
            tick();
            start = 1'b0;
            cycles++;
            if (cycles == 1) chk("busy_first_cycle", 32'(busy_t), 1);
            if (cycles == poke_at) start = 1'b1;
            if (cycles == dir_at) pacman_dir = dir2;
        end while (!done_t && cycles < 400);
        chk("busy_with_done", 32'(busy_t), 1);
        tick();
        chk("busy_after_done", 32'(busy_t), 0);
        chk("done_one_cycle", 32'(done_t), 0);
        tick();
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; pacman_dir = 2'd0;
        char_visible = 5'b11111; pos_x = '0; pos_y = '0;
        clr_mon();
        repeat (3) tick();
        chk("reset_outs_t", 32'({char_sel_t, vga_x_t, vga_y_t, vga_color_t,
                                 vga_plot_t, busy_t, done_t}), 0);
        chk("reset_outs_o", 32'({char_sel_o, vga_x_o, vga_y_o, vga_color_o,
                                 vga_plot_o, busy_o, done_o}), 0);

        // Default frame, start on the first cycle out of reset.
        run_frame(5'b11111, 2'd0, 8'd0, 8'd0, -1, -1, 2'd0, 1'b1, cyc);
        chk("dflt_cycles", cyc, 137);
        chk("dflt_plots", plots_t, 53);
        chk("dflt_first_x", 32'(first_x), 1);
        chk("dflt_first_y", 32'(first_y), 1);
        chk("dflt_first_col", 32'(first_col), 6);
        chk("dflt_dones", dones_t, 1);
        chk("col_char0", 32'(char_col[0]), 6);
        chk("col_char1", 32'(char_col[1]), 1);
        chk("col_char2", 32'(char_col[2]), 4);
        chk("col_char3", 32'(char_col[3]), 2);
        chk("col_char4", 32'(char_col[4]), 6);
        chk("opaque_plots", plots_o, 125);
        chk("opaque_ghost_row4_clear", ghost_r4_clear_o, 20);
        chk("opaque_dones", dones_o, 1);

        // Only characters 0 and 2 visible.
        run_frame(5'b00101, 2'd0, 8'd0, 8'd0, -1, -1, 2'd0, 1'b0, cyc);
        chk("vis_cycles", cyc, 62);
        chk("vis_plots", plots_t, 26);
        chk("vis_col_char2", 32'(char_col[2]), 4);
        chk("vis_no_char1", 32'(char_col[1]), 7);

        // Pacman right at (36,36): coordinates wrap; dir change mid-sprite ignored.
        run_frame(5'b00001, 2'd1, 8'd36, 8'd36, -1, 5, 2'd0, 1'b0, cyc);
        chk("wrap_cycles", cyc, 37);
        chk("wrap_plots", plots_t, 21);
        chk("wrap_first_x", 32'(first_x), 253);
        chk("wrap_first_y", 32'(first_y), 253);
        chk("wrap_last_x", 32'(last_x), 1);
        chk("wrap_last_y", 32'(last_y), 1);
        chk("wrap_x0_count", x0_t, 4);
        chk("wrap_col", 32'(first_col), 6);

        // Pacman up (transpose of left).
        run_frame(5'b00001, 2'd2, 8'd0, 8'd0, -1, -1, 2'd0, 1'b0, cyc);
        chk("up_plots", plots_t, 17);
        chk("up_last_x", 32'(last_x), 2);
        chk("up_last_y", 32'(last_y), 5);

        // Pacman down (transpose of right).
        run_frame(5'b00001, 2'd3, 8'd0, 8'd0, -1, -1, 2'd0, 1'b0, cyc);
        chk("down_plots", plots_t, 21);
        chk("down_row0", row0_t, 4);
        chk("down_last_x", 32'(last_x), 5);
        chk("down_last_y", 32'(last_y), 5);

        // start pulsed mid-frame must be ignored.
        run_frame(5'b11111, 2'd0, 8'd0, 8'd0, 50, -1, 2'd0, 1'b0, cyc);
        chk("poke_cycles", cyc, 137);
        repeat (20) tick();
        chk("poke_dones", dones_t, 1);
        chk("poke_idle_busy", 32'(busy_t), 0);

        // Reset at cycle 40 of a frame aborts it.
        clr_mon();
        char_visible = 5'b11111;
        pacman_dir   = 2'd0;
        start = 1'b1;
        tick();
        start = 1'b0;
        repeat (39) tick();
        reset = 1'b1;
        tick();
        chk("midrst_outs", 32'({char_sel_t, vga_x_t, vga_y_t, vga_color_t,
                                vga_plot_t, busy_t, done_t}), 0);
        reset = 1'b0;
        clr_mon();
        repeat (150) tick();
        chk("midrst_no_done", dones_t, 0);
        chk("midrst_no_plot", plots_t, 0);
        run_frame(5'b11111, 2'd0, 8'd0, 8'd0, -1, -1, 2'd0, 1'b0, cyc);
        chk("after_rst_cycles", cyc, 137);
        chk("after_rst_plots", plots_t, 53);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
